// File: rtl/ifetch_sram_bridge.sv
// ifetch_sram_bridge: instruction-fetch slave serving pc->ir requests from a
// single-port synchronous SRAM with one cycle of read latency.
//  - Fully pipelined: a request may be accepted every cycle while the
//    response buffer plus the read in flight leave room (occ < DEPTH).
//  - Responses return strictly in request order. Returning SRAM data
//    bypasses the buffer only when the buffer is empty.
//  - The request side never looks at rsp_rdy combinationally.
// Optional feature: define IFETCH_BRIDGE_FLUSH_EN to add a 'flush' input
// that discards buffered responses and the read in flight (branch redirect).
module ifetch_sram_bridge #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SRAM_AW = 15,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
`ifdef IFETCH_BRIDGE_FLUSH_EN
   input  logic               flush,
`endif
   input  logic               req_vld,
   output logic               req_rdy,
   input  logic [AW-1:0]      req_pc,
   output logic               rsp_vld,
   input  logic               rsp_rdy,
   output logic [DW-1:0]      rsp_ir,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic               sram_wen,
   output logic [DW-1:0]      sram_wdata,
   input  logic [DW-1:0]      sram_rdata
);

   localparam int OFF = $clog2(DW / 8);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Parameter legality, caught at elaboration.
   if (DW < 8 || (DW & (DW - 1)) != 0) begin : g_bad_dw
      $error("ifetch_sram_bridge: DW must be a power of two, 8 or more");
   end
   if (SRAM_AW + OFF > AW) begin : g_bad_aw
      $error("ifetch_sram_bridge: SRAM_AW + OFF must not exceed AW");
   end
   if (DEPTH < 1) begin : g_bad_depth
      $error("ifetch_sram_bridge: DEPTH must be 1 or more");
   end

   // Advance a buffer pointer, wrapping modulo DEPTH (DEPTH need not be 2^n).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == PW'(DEPTH - 1)) begin
         r = {PW{1'b0}};
      end else begin
         r = p + PW'(1);
      end
      return r;
   endfunction

   // State
   logic              inflight_q, inflight_d;
   logic [CW-1:0]     count_q,    count_d;
   logic [PW-1:0]     rd_ptr_q,   rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q,   wr_ptr_d;
   logic [DW-1:0]     mem_q [DEPTH];
   logic [DW-1:0]     mem_d [DEPTH];

   // Internal
   logic              flush_s;
   logic [CW:0]       occ_s;
   logic              fire_s;
   logic              push_s;
   logic              pop_s;
   logic              buf_empty_s;
   logic              pc_unused_s;

`ifdef IFETCH_BRIDGE_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   // Low byte-offset bits and bits above the SRAM window are dropped on purpose
   // (truncation of misaligned pc, aliasing above the SRAM size).
   assign pc_unused_s = ^req_pc;

   // The SRAM is read-only from this port.
   assign sram_wen   = 1'b0;
   assign sram_wdata = {DW{1'b0}};

   // Word address straight from the pc, every cycle.
   assign sram_addr = req_pc[SRAM_AW+OFF-1:OFF];

   // Occupancy, request acceptance and response muxing.
   always_comb begin
      occ_s       = {1'b0, count_q} + (CW + 1)'(inflight_q);
      buf_empty_s = (count_q == {CW{1'b0}});

      // Acceptance depends on registered state only, never on rsp_rdy.
      if (rst || flush_s) begin
         req_rdy = 1'b0;
      end else begin
         req_rdy = (occ_s < (CW + 1)'(DEPTH));
      end
      fire_s = req_vld & req_rdy;

      // Head of the buffer has priority; bypass only when the buffer is empty
      // so that ordering is preserved.
      if (rst || flush_s) begin
         rsp_vld = 1'b0;
         rsp_ir  = {DW{1'b0}};
      end else if (!buf_empty_s) begin
         rsp_vld = 1'b1;
         rsp_ir  = mem_q[rd_ptr_q];
      end else if (inflight_q) begin
         rsp_vld = 1'b1;
         rsp_ir  = sram_rdata;
      end else begin
         rsp_vld = 1'b0;
         rsp_ir  = {DW{1'b0}};
      end

      // Returning data is buffered unless the bypass consumes it this cycle.
      if (rst || flush_s) begin
         push_s = 1'b0;
         pop_s  = 1'b0;
      end else begin
         push_s = inflight_q & ~(buf_empty_s & rsp_rdy);
         pop_s  = ~buf_empty_s & rsp_rdy;
      end
   end

   // Next-state for inflight flag, count, pointers and buffer storage.
   always_comb begin
      inflight_d = fire_s;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      mem_d      = mem_q;

      if (flush_s) begin
         inflight_d = 1'b0;
         count_d    = {CW{1'b0}};
         rd_ptr_d   = {PW{1'b0}};
         wr_ptr_d   = {PW{1'b0}};
      end else begin
         if (push_s) begin
            mem_d[wr_ptr_q] = sram_rdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with synchronous reset discarding all traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         count_q    <= {CW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         wr_ptr_q   <= {PW{1'b0}};
      end else begin
         inflight_q <= inflight_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Buffer storage; contents are meaningless while count is zero, so no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: tb/tb_ifetch_sram_bridge.sv
// Self-checking bench for ifetch_sram_bridge (default parameters, DEPTH=2).
// Reference model: a queue of outstanding expected instructions. At the start
// of each cycle, queue size equals occupancy; a response is due whenever the
// queue is non-empty, and it must equal the queue head.
module tb_ifetch_sram_bridge;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int SRAM_AW = 15;
   localparam int DEPTH   = 2;

   logic               clk;
   logic               rst;
   logic               flush;
   logic               req_vld;
   logic               req_rdy;
   logic [AW-1:0]      req_pc;
   logic               rsp_vld;
   logic               rsp_rdy;
   logic [DW-1:0]      rsp_ir;
   logic [SRAM_AW-1:0] sram_addr;
   logic               sram_wen;
   logic [DW-1:0]      sram_wdata;
   logic [DW-1:0]      sram_rdata;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] exp_q[$];
   logic          hold_prev;
   logic [DW-1:0] prev_ir;
   int            fires;

   ifetch_sram_bridge #(
      .AW(AW), .DW(DW), .SRAM_AW(SRAM_AW), .DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef IFETCH_BRIDGE_FLUSH_EN
      .flush      (flush),
`endif
      .req_vld    (req_vld),
      .req_rdy    (req_rdy),
      .req_pc     (req_pc),
      .rsp_vld    (rsp_vld),
      .rsp_rdy    (rsp_rdy),
      .rsp_ir     (rsp_ir),
      .sram_addr  (sram_addr),
      .sram_wen   (sram_wen),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: word n holds 0x1000 + n, one cycle read latency.
   always @(posedge clk) sram_rdata <= 32'h1000 + 32'(sram_addr);

   function automatic logic [DW-1:0] word_of(input logic [AW-1:0] pc);
      return 32'h1000 + ((pc >> 2) & 32'h7FFF);
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: check outputs mid-cycle against the model, update model.
   task automatic cycle();
      @(negedge clk);
      check_eq("sram_addr", 64'(sram_addr), 64'((req_pc >> 2) & 32'h7FFF));
      check_eq("sram_wen", 64'(sram_wen), 64'd0);
      check_eq("sram_wdata", 64'(sram_wdata), 64'd0);
      if (rst || flush) begin
         check_eq("rdy_in_rst_flush", 64'(req_rdy), 64'd0);
         check_eq("vld_in_rst_flush", 64'(rsp_vld), 64'd0);
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         check_eq("req_rdy", 64'(req_rdy), 64'(exp_q.size() < DEPTH));
         check_eq("rsp_vld", 64'(rsp_vld), 64'(exp_q.size() > 0));
         if (rsp_vld && exp_q.size() > 0) check_eq("rsp_ir", 64'(rsp_ir), 64'(exp_q[0]));
         if (hold_prev) begin
            check_eq("hold_vld", 64'(rsp_vld), 64'd1);
            check_eq("hold_ir", 64'(rsp_ir), 64'(prev_ir));
         end
         if (rsp_vld && rsp_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
         if (req_vld && req_rdy) begin
            exp_q.push_back(word_of(req_pc));
            fires++;
         end
         check_eq("occ_le_depth", 64'(exp_q.size() <= DEPTH), 64'd1);
         hold_prev = rsp_vld & ~rsp_rdy;
         prev_ir   = rsp_ir;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [AW-1:0] pc, input logic rdy);
      req_vld = vld;
      req_pc  = pc;
      rsp_rdy = rdy;
      cycle();
   endtask

   // Keep presenting one request until accepted (bounded).
   task automatic fetch(input logic [AW-1:0] pc, input logic rdy);
      int f0;
      f0 = fires;
      for (int i = 0; i < 20 && fires == f0; i++) drive(1'b1, pc, rdy);
      check_eq("fetch_accepted", 64'(fires - f0), 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() > 0; i++) drive(1'b0, $urandom, 1'b1);
      check_eq("drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int f0;
      rst = 1'b1; flush = 1'b0; req_vld = 1'b0; req_pc = '0; rsp_rdy = 1'b0;
      hold_prev = 1'b0; prev_ir = '0; fires = 0;
      sram_rdata = '0;
      repeat (3) cycle();
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0);

      // 1. Streaming back-to-back, one response per cycle.
      for (int i = 0; i < 4; i++) begin
         f0 = fires;
         drive(1'b1, 32'(4 * i), 1'b1);
         check_eq("stream_fire", 64'(fires - f0), 64'd1);
      end
      drain();

      // 2. Backpressure: only DEPTH requests accepted while rsp_rdy=0.
      f0 = fires;
      for (int i = 0; i < 3; i++) drive(1'b1, 32'(4 * i), 1'b0);
      check_eq("bp_accepted", 64'(fires - f0), 64'd2);
      drive(1'b0, 32'h0, 1'b0);
      check_eq("bp_head", 64'(rsp_ir), 64'h1000);
      drain();

      // 3. Stall hold with rsp_rdy toggling over 8 fetches.
      for (int i = 0; i < 8; i++) fetch(32'(32'h100 + 4 * i), 1'(i & 1));
      drain();

      // 4. Aliasing and misalignment both map to word 1.
      req_pc = 32'h0002_0004; #1;
      check_eq("alias_addr_hi", 64'(sram_addr), 64'd1);
      req_pc = 32'h6; #1;
      check_eq("alias_addr_lo", 64'(sram_addr), 64'd1);
      fetch(32'h0002_0004, 1'b1);
      fetch(32'h6, 1'b1);
      drain();

      // 5. Reset with buffer full plus a read in flight.
      for (int i = 0; i < 3; i++) drive(1'b1, 32'(4 * i), 1'b0);
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 1'b1);
         check_eq("post_rst_no_rsp", 64'(rsp_vld), 64'd0);
      end
      fetch(32'h10, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
      check_eq("post_rst_word4", 64'(rsp_ir), 64'h1004);
      drain();

`ifdef IFETCH_BRIDGE_FLUSH_EN
      // 6. Flush with one buffered and one in flight.
      drive(1'b1, 32'h0, 1'b0);
      drive(1'b1, 32'h4, 1'b0);
      flush = 1'b1;
      drive(1'b0, 32'h0, 1'b1);
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b1);
      check_eq("post_flush_no_rsp", 64'(rsp_vld), 64'd0);
      fetch(32'h20, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      check_eq("post_flush_word8", 64'(rsp_ir), 64'h1008);
      drain();
`endif

      // 7. Random traffic with occasional reset (and flush when present).
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
`ifdef IFETCH_BRIDGE_FLUSH_EN
         flush = ($urandom_range(0, 49) == 0);
`endif
         drive(1'($urandom), $urandom, 1'($urandom_range(0, 3) != 0));
      end
      rst = 1'b0;
      flush = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifetch_sram_bridge.md
Name: ifetch_sram_bridge

Overview:
- Parametrised instruction-fetch slave that serves ifetch req/rsp (pc in, ir out) from a single-port synchronous SRAM with 1-cycle read latency.
- Sits between the core fetch stage (master) and the instruction SRAM (slave).
- Adds what a plain ifetch port lacks: configurable response buffering, full-throughput pipelining with in-order responses under backpressure, and parametrised pc/data/SRAM widths.

Parameters:
- AW, 32, pc width.
- DW, 32, instruction/SRAM data width; must be a power of two, 8 or more.
- SRAM_AW, 15, SRAM word-address width; must satisfy SRAM_AW + OFF <= AW.
- DEPTH, 2, response buffer entries (1 or more); 2 or more gives 1 fetch/cycle.
- Derived: OFF = $clog2(DW/8).
- Derived: CW = $clog2(DEPTH+1).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_vld  input  1  fetch request valid
- req_rdy  output  1  fetch request ready
- req_pc  input  AW  fetch byte address
- rsp_vld  output  1  response valid
- rsp_rdy  input  1  response ready
- rsp_ir  output  DW  fetched instruction
- sram_addr  output  SRAM_AW  SRAM word address
- sram_wen  output  1  SRAM write enable; tied 0
- sram_wdata  output  DW  SRAM write data; tied 0
- sram_rdata  input  DW  SRAM read data, valid the cycle after the address

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- State:
  - inflight (1b): read issued last cycle.
  - FIFO of DEPTH x DW with rd/wr pointers and count (CW bits).
  - occ = count + inflight.
- Reset: inflight=0, count=0, pointers=0.
- Outputs while rst=1: req_rdy=0, rsp_vld=0, sram_wen=0, sram_wdata=0.
- Address mapping:
  - sram_addr = req_pc[SRAM_AW+OFF-1:OFF], combinational, every cycle.
  - Low OFF bits are ignored (misaligned pc is truncated).
  - Bits above SRAM_AW+OFF are ignored (aliasing/wrap).
- Request acceptance:
  - req_rdy = (occ < DEPTH); no combinational path from rsp_rdy.
  - Fire = req_vld & req_rdy; sets inflight=1 next cycle, else inflight=0.
  - req_pc may change freely when fire=0.
- Response path:
  - Bypass: if count==0 and inflight, then rsp_vld=1 and rsp_ir=sram_rdata (latency 1 cycle from fire).
  - FIFO: if count>0, then rsp_vld=1 and rsp_ir=FIFO head.
  - Otherwise rsp_vld=0 and rsp_ir=0.
  - Returning data (inflight=1) is pushed into the FIFO unless it is consumed via bypass in the same cycle (count==0 & rsp_rdy).
  - Pop head when count>0 & rsp_rdy.
  - Push and pop may occur in the same cycle; count is unchanged.
- Ordering: responses are strictly in request order; bypass is used only when the FIFO is empty.
- Overflow is impossible by construction; the bench asserts count <= DEPTH and occ <= DEPTH.
- rsp_vld, once high, stays high with rsp_ir stable until rsp_rdy (except on reset or flush).
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Throughput:
  - DEPTH >= 2 with rsp_rdy held 1: one response per cycle.
  - DEPTH = 1: one response every 2 cycles.
- Reset mid-operation: any in-flight read and all FIFO contents are discarded; no response appears after rst deasserts.

Optional Feature:
- Macro: IFETCH_BRIDGE_FLUSH_EN.
- When defined:
  - Adds input flush (1b).
  - In a cycle with flush=1: req_rdy=0, rsp_vld=0, FIFO count and pointers cleared next cycle.
  - A read in flight that cycle is discarded (inflight cleared, sram_rdata neither pushed nor presented).
  - Normal operation resumes the cycle after flush deasserts.
  - Used on branch redirect.
- When undefined: no flush port; behaviour as above.

Test Plan:
1. Streaming: req_pc=0x0,0x4,0x8,0xC back-to-back, rsp_rdy=1, SRAM word n = 0x1000+n -> rsp_ir 0x1000..0x1003 on 4 consecutive cycles starting 1 cycle after first fire.
2. Backpressure, DEPTH=2: rsp_rdy=0 and 3 requests -> only 2 accepted, req_rdy=0 after that. rsp_rdy=1 -> 0x1000, 0x1001 in order, then req_rdy=1 again.
3. Stall hold: rsp_rdy toggling 0/1 every cycle over 8 fetches -> no lost, duplicated or reordered responses; rsp_ir stable while rsp_vld & !rsp_rdy.
4. Aliasing: with SRAM_AW=15, req_pc=0x0002_0004 and req_pc=0x6 -> both give sram_addr=1 and return word 1.
5. Reset mid-stream: assert rst with FIFO full plus inflight -> rsp_vld=0 and req_rdy=0 during reset; after release occ=0 and no stale response; next fetch of 0x10 returns word 4.
6. Flush (IFETCH_BRIDGE_FLUSH_EN): flush while 1 buffered and 1 in flight -> rsp_vld=0 the next 2 cycles; fetch of 0x20 then returns word 8 only.
